fpall_result_collector: RTL and testbench
=========================================

# fpall_result_collector

Result-side companion to `fpall_shared`. It tracks every operation issued into the pipelined FP datapath and captures the datapath output `R` exactly `LATENCY` cycles after issue. Captured results are tagged and buffered in an output FIFO, then presented downstream on a valid/ready interface. Credit-based issue gating guarantees the FIFO never overflows, so `fpall_shared` itself needs no stall logic.

## Interface
- `LATENCY`, 2: cycles from operands presented to `fpall_shared` until the matching `R` is valid; legal range 1..8.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the opaque issue tag.
- `i_clk`  input  1  clock, rising edge.
- `i_rst`  input  1  synchronous reset, active-high.
- `i_issue_valid`  input  1  issuer presents an operation to `fpall_shared` this cycle.
- `o_issue_ready`  output  1  credit available; issue accepted when valid && ready.
- `i_issue_tag`  input  TAG_W  tag returned with the result.
- `i_issue_op`  input  opcode_t  opcode driven to datapath (OP_ADD/OP_MUL/OP_SQRT).
- `i_issue_fmt`  input  fmt_t  FP32 or FP16 (dual-lane BF16).
- `i_dp_r`  input  32  `fpall_shared` R output.
- `o_res_valid`  output  1  FIFO head valid.
- `i_res_ready`  input  1  consumer accepts head.
- `o_res_data`  output  32  result word; in FP16 mode `[31:16]` = lane 1, `[15:0]` = lane 0.
- `o_res_tag`  output  TAG_W  tag of head.
- `o_res_op`  output  opcode_t  opcode of head.
- `o_res_fmt`  output  fmt_t  format of head.
- `o_inflight`  output  $clog2(FIFO_DEPTH+1)  in-flight ops plus FIFO occupancy.

## Operation
- Tracking pipe: `LATENCY` stages of {valid, tag, op, fmt}.
  - Stage 0 loads on an accepted issue; valid=0 otherwise.
  - Advances every cycle; never stalls.
- Capture: when the last stage is valid, `i_dp_r` is written to the FIFO together with that stage's tag/op/fmt in the same cycle. `i_dp_r` is ignored when the last stage is invalid.
- Credits:
  - `o_issue_ready = (o_inflight < FIFO_DEPTH)`.
  - A same-cycle pop does not free a credit until the following cycle.
  - `o_inflight` increments on accepted issue and decrements on pop; a simultaneous issue and pop leaves it unchanged.
- FIFO push/pop:
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push into a full FIFO without a pop is unreachable by construction. Assert on it in simulation.
- Output data is held stable while `o_res_valid && !i_res_ready`.
- Reset (including mid-operation):
  - Clears tracking valids, FIFO pointers and count, and `o_inflight`.
  - Results of operations in flight are discarded.
  - Datapath outputs arriving after reset are ignored because the tracking valids are cleared.

## Timing
- Reset values: `o_res_valid`=0, `o_res_data`=0, `o_res_tag`=0, `o_res_op`=OP_ADD, `o_res_fmt`=FP32, `o_inflight`=0, `o_issue_ready`=0 while `i_rst` is high and 1 in the first cycle after.
- Issue accepted in cycle t → written to FIFO at the edge ending cycle t+LATENCY → `o_res_valid` in cycle t+LATENCY+1 if the FIFO was empty. Total latency is LATENCY+1.
- Credit loop: a credit consumed at t returns at t+LATENCY+2 at the earliest. Sustained one op per cycle requires `FIFO_DEPTH ≥ LATENCY+2`; smaller depths throttle throughput and remain correct.
- Results are returned strictly in issue order.

## Configuration
- `FPALL_COLLECT_NAN_FLAG_EN` defined: adds an output `o_res_nan` [1:0], stored per FIFO entry and computed at capture. Reset value 0.
  - FP32: bit0 = (exp==8'hFF && mant!=0); bit1=0.
  - FP16: bit n = BF16 NaN test on lane n.
- `FPALL_COLLECT_NAN_FLAG_EN` undefined: the port and its storage are absent.

## Structure
- In `fpall_pkg`: `fpall_result_t` struct {data, tag, op, fmt[, nan]} and the constant `FPALL_MAX_LATENCY`=8.
- `opcode_t` and `fmt_t` are reused from `fpall_pkg`.
- One sub-module, `fpall_result_fifo`, parameterised on `fpall_result_t` and depth. Tracking pipe and credit counter live in the top.

## Test plan
- FP32 add, tag 3, X=0x3F800000, Y=0x40000000 → `o_res_valid` at cycle LATENCY+1 with data 0x40400000, tag 3, op OP_ADD.
- FP16 mul, X={0x3F80,0x4000}, Y={0x4000,0x4040} → data 0x400040C0 (lane1 2.0, lane0 6.0).
- Backpressure: `i_res_ready`=0, issue every cycle → exactly FIFO_DEPTH accepted, `o_issue_ready`=0, `o_inflight`=FIFO_DEPTH. Release ready → results appear in tag order 0,1,2,3 with no loss or duplication.
- Back-to-back stream of 16 ops with `i_res_ready`=1, LATENCY=2, FIFO_DEPTH=4 → one issue accepted per cycle and one result per cycle after the initial latency.
- Reset asserted with 2 ops in flight and 1 in the FIFO → after reset `o_res_valid` stays 0 for 10 cycles, `o_inflight`=0, and a new issue returns normally.
- With the macro defined: sqrt of 0xBF800000 → NaN data, `o_res_nan`=2'b01. FP32 1.0+2.0 → `o_res_nan`=0.

Source files
------------

// File: rtl/fpall_pkg.sv
// -----------------------------------------------------------------------------
// fpall_pkg
// Shared types for the fpall FP datapath and its result collector.
//   opcode_t        : datapath operation (add / mul / sqrt)
//   fmt_t           : FP32, or FP16 mode (two BF16 lanes packed in 32 bits)
//   fpall_result_t  : one buffered result {data, tag, op, fmt[, nan]}
//   fpall_track_t   : one tracking-pipe stage {valid, tag, op, fmt}
// Optional feature macro: FPALL_COLLECT_NAN_FLAG_EN adds per-result NaN flags.
// -----------------------------------------------------------------------------
package fpall_pkg;

  // Deepest datapath the collector is meant to track.
  localparam int FPALL_MAX_LATENCY = 8;

  // Tag storage width inside the shared structs. The collector's TAG_W must
  // not exceed this; narrower tags are zero-extended on the way in.
  localparam int FPALL_MAX_TAG_W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_MUL  = 2'd1,
    OP_SQRT = 2'd2
  } opcode_t;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fmt_t;

  typedef struct packed {
    logic [31:0]                data;
    logic [FPALL_MAX_TAG_W-1:0] tag;
    opcode_t                    op;
    fmt_t                       fmt;
`ifdef FPALL_COLLECT_NAN_FLAG_EN
    logic [1:0]                 nan;
`endif
  } fpall_result_t;

  typedef struct packed {
    logic                       valid;
    logic [FPALL_MAX_TAG_W-1:0] tag;
    opcode_t                    op;
    fmt_t                       fmt;
  } fpall_track_t;

`ifdef FPALL_COLLECT_NAN_FLAG_EN
  // NaN = all-ones exponent with a non-zero mantissa. In FP16 mode each
  // 16-bit half is a BF16 value (8-bit exponent, 7-bit mantissa).
  function automatic logic [1:0] nan_flags(input logic [31:0] r, input fmt_t fmt);
    logic [1:0] f;
    f = 2'b00;
    if (fmt == FP32) begin
      f[0] = (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
    end else begin
      f[0] = (r[14:7]  == 8'hFF) && (r[6:0]   != 7'd0);
      f[1] = (r[30:23] == 8'hFF) && (r[22:16] != 7'd0);
    end
    return f;
  endfunction
`endif

endpackage

// File: rtl/fpall_result_fifo.sv
// -----------------------------------------------------------------------------
// fpall_result_fifo
// Small synchronous FIFO of result records with a show-ahead head.
// Parameters: T (record type), DEPTH (power of two, >= 2).
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_push/i_data : write one record
//   i_pop         : consume the head (ignored when empty)
//   o_valid       : head present
//   o_data        : head record; all-zero when empty
// Push and pop may coincide even when full. A push into a full FIFO without
// a pop is never produced by the collector's credit scheme and is asserted.
// -----------------------------------------------------------------------------
module fpall_result_fifo
  import fpall_pkg::*;
#(
  parameter type T     = fpall_result_t,
  parameter int  DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_valid,
  output T     o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = i_pop && !empty;
  // A pop in the same cycle makes room, so a full FIFO still accepts a push.
  assign do_push = i_push && (!full || do_pop);

  // NOTE: the storage array is deliberately not reset; the count/pointers
  // define which entries are meaningful, and o_data is masked when empty.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: the pointers wrap by plain overflow.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_valid = !empty;
  // Zero when empty gives the required idle/reset values on the outputs and
  // keeps stale storage contents from showing.
  assign o_data  = empty ? '0 : mem[rd_ptr];

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && full && !i_pop));

endmodule

// File: rtl/fpall_result_collector.sv
// -----------------------------------------------------------------------------
// fpall_result_collector
// Result-side companion to fpall_shared. Tracks each issued operation through
// a LATENCY-deep shadow pipe, captures the datapath R output when the shadow
// reaches its last stage, and buffers {data, tag, op, fmt} in a FIFO presented
// on a valid/ready interface. Issue is credit-gated so the FIFO cannot
// overflow and the datapath never needs to stall.
// Parameters: LATENCY (1..FPALL_MAX_LATENCY), FIFO_DEPTH (power of two, >=2),
//             TAG_W (<= FPALL_MAX_TAG_W).
// Ports:
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_issue_valid / o_issue_ready   : issue handshake (ready = credit left)
//   i_issue_tag/op/fmt              : issue attributes returned with result
//   i_dp_r                          : fpall_shared R output
//   o_res_valid / i_res_ready       : result handshake
//   o_res_data/tag/op/fmt           : head result
//   o_inflight                      : ops in flight plus FIFO occupancy
//   o_res_nan (optional)            : NaN flags of the head result
// Optional feature macro: FPALL_COLLECT_NAN_FLAG_EN.
// -----------------------------------------------------------------------------
module fpall_result_collector
  import fpall_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_issue_valid,
  output logic                            o_issue_ready,
  input  logic [TAG_W-1:0]                i_issue_tag,
  input  opcode_t                         i_issue_op,
  input  fmt_t                            i_issue_fmt,
  input  logic [31:0]                     i_dp_r,
  output logic                            o_res_valid,
  input  logic                            i_res_ready,
  output logic [31:0]                     o_res_data,
  output logic [TAG_W-1:0]                o_res_tag,
  output opcode_t                         o_res_op,
  output fmt_t                            o_res_fmt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_inflight
`ifdef FPALL_COLLECT_NAN_FLAG_EN
  ,
  output logic [1:0]                      o_res_nan
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic          fire;
  logic          pop;
  fpall_track_t  track_in;
  fpall_track_t  pipe [LATENCY];
  fpall_track_t  last;
  fpall_result_t res_in;
  fpall_result_t res_out;
  logic [CNT_W-1:0] inflight;
  logic          unused_tag_bits;

  assign fire = i_issue_valid && o_issue_ready;
  assign pop  = o_res_valid && i_res_ready;

  // ---------------------------------------------------------------------------
  // Tracking pipe: shadows the datapath one stage per cycle, never stalls.
  // ---------------------------------------------------------------------------
  assign track_in = '{valid: fire,
                      tag:   FPALL_MAX_TAG_W'(i_issue_tag),
                      op:    i_issue_op,
                      fmt:   i_issue_fmt};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Clearing the valids discards in-flight ops; their R values arriving
      // later are then ignored.
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= track_in;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign last = pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Capture: the last shadow stage lines up with the datapath R output.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    res_in      = '0;
    res_in.data = i_dp_r;
    res_in.tag  = last.tag;
    res_in.op   = last.op;
    res_in.fmt  = last.fmt;
`ifdef FPALL_COLLECT_NAN_FLAG_EN
    res_in.nan  = nan_flags(i_dp_r, last.fmt);
`endif
  end

  fpall_result_fifo #(
    .T     (fpall_result_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (last.valid),
    .i_data  (res_in),
    .i_pop   (pop),
    .o_valid (o_res_valid),
    .o_data  (res_out)
  );

  assign o_res_data = res_out.data;
  assign o_res_tag  = res_out.tag[TAG_W-1:0];
  assign o_res_op   = res_out.op;
  assign o_res_fmt  = res_out.fmt;
`ifdef FPALL_COLLECT_NAN_FLAG_EN
  assign o_res_nan  = res_out.nan;
`endif

  // Tag bits above TAG_W are always zero; fold them so they read as consumed.
  assign unused_tag_bits = ^res_out.tag;

  // ---------------------------------------------------------------------------
  // Credits: one per FIFO entry. A credit is taken at issue and returned only
  // when the result leaves the FIFO, so every tracked op has a slot waiting.
  // The counter is registered, so a pop frees its credit one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign o_inflight    = inflight;
  assign o_issue_ready = !i_rst && (inflight < CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fpall_result_collector.sv
module tb_fpall_result_collector;
  import fpall_pkg::*;

  localparam int L  = 2;
  localparam int D  = 4;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [TW-1:0] issue_tag;
  opcode_t       issue_op;
  fmt_t          issue_fmt;
  logic [31:0]   dp_r;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [TW-1:0] res_tag;
  opcode_t       res_op;
  fmt_t          res_fmt;
  logic [2:0]    inflight;
`ifdef FPALL_COLLECT_NAN_FLAG_EN
  logic [1:0]    res_nan;
`endif

  fpall_result_collector #(.LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .o_issue_ready (issue_ready),
    .i_issue_tag   (issue_tag),
    .i_issue_op    (issue_op),
    .i_issue_fmt   (issue_fmt),
    .i_dp_r        (dp_r),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_res_tag     (res_tag),
    .o_res_op      (res_op),
    .o_res_fmt     (res_fmt),
    .o_inflight    (inflight)
`ifdef FPALL_COLLECT_NAN_FLAG_EN
    ,
    .o_res_nan     (res_nan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for fpall_shared: the value the datapath would produce for the
  // op accepted at an edge appears on R exactly L cycles later; junk otherwise.
  logic [31:0] cur_dp;
  logic [31:0] dp_sh [L];
  always @(posedge clk) begin
    dp_sh[0] <= (issue_valid && issue_ready) ? cur_dp : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) dp_sh[i] <= dp_sh[i-1];
  end
  assign dp_r = dp_sh[L-1];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op at the current negedge and wait (bounded) for its result.
  task automatic issue_and_wait(input logic [TW-1:0] tag, input opcode_t op, input fmt_t fmt,
                                input logic [31:0] dp, output int lat);
    issue_valid = 1'b1;
    issue_tag   = tag;
    issue_op    = op;
    issue_fmt   = fmt;
    cur_dp      = dp;
    step();
    issue_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    opcode_t       op;
    fmt_t          fmt;
    logic [TW-1:0] tag;
    logic [31:0]   data;   // R from the datapath = expected result word
    logic [1:0]    nan;
  } vec_t;

  vec_t vecs [6];

  int lat, acc, rx, tx, stalls, first_c, last_c, bad;

  initial begin
    vecs[0] = '{OP_ADD,  FP32, 4'h3, 32'h4040_0000, 2'b00}; // 1.0 + 2.0 = 3.0
    vecs[1] = '{OP_MUL,  FP16, 4'h5, 32'h4000_40C0, 2'b00}; // {1,2}*{2,3} = {2,6}
    vecs[2] = '{OP_SQRT, FP32, 4'h9, 32'h7FC0_0000, 2'b01}; // sqrt(-1) = NaN
    vecs[3] = '{OP_ADD,  FP32, 4'hF, 32'h7F80_0000, 2'b00}; // +inf is not NaN
    vecs[4] = '{OP_MUL,  FP16, 4'hC, 32'h7FC1_3F80, 2'b10}; // lane1 NaN
    vecs[5] = '{OP_SQRT, FP16, 4'h0, 32'hFF80_7F81, 2'b01}; // lane1 -inf, lane0 NaN

    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; issue_op = OP_ADD;
    issue_fmt = FP32; cur_dp = '0; res_ready = 1'b0;
    repeat (2) step();

    check("rst_valid",    32'(res_valid),   0);
    check("rst_data",     res_data,         0);
    check("rst_tag",      32'(res_tag),     0);
    check("rst_op",       32'(res_op),      32'(OP_ADD));
    check("rst_fmt",      32'(res_fmt),     32'(FP32));
    check("rst_inflight", 32'(inflight),    0);
    check("rst_ready",    32'(issue_ready), 0);
`ifdef FPALL_COLLECT_NAN_FLAG_EN
    check("rst_nan",      32'(res_nan),     0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(issue_ready), 1);

    // Single ops, one at a time, consumer always ready.
    res_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      issue_and_wait(vecs[v].tag, vecs[v].op, vecs[v].fmt, vecs[v].data, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat),        32'(L + 1));
      check($sformatf("vec%0d_data", v),    res_data,        vecs[v].data);
      check($sformatf("vec%0d_tag", v),     32'(res_tag),    32'(vecs[v].tag));
      check($sformatf("vec%0d_op", v),      32'(res_op),     32'(vecs[v].op));
      check($sformatf("vec%0d_fmt", v),     32'(res_fmt),    32'(vecs[v].fmt));
`ifdef FPALL_COLLECT_NAN_FLAG_EN
      check($sformatf("vec%0d_nan", v),     32'(res_nan),    32'(vecs[v].nan));
`endif
      step();
      check($sformatf("vec%0d_popped", v),  32'(res_valid),  0);
    end

    // Back-to-back stream of 16 ops with the consumer always ready.
    rx = 0; tx = 0; stalls = 0; first_c = -1; last_c = -1;
    issue_op = OP_ADD; issue_fmt = FP32;
    for (int c = 0; c < 40 && rx < 16; c++) begin
      if (res_valid) begin
        check("stream_tag",  32'(res_tag), 32'(rx & 15));
        check("stream_data", res_data,     32'hC000_0000 | 32'(rx));
        if (first_c < 0) first_c = c;
        last_c = c;
        rx++;
      end
      if (tx < 16) begin
        issue_valid = 1'b1;
        issue_tag   = TW'(tx);
        cur_dp      = 32'hC000_0000 | 32'(tx);
        if (issue_ready) tx++;
        else stalls++;
      end else begin
        issue_valid = 1'b0;
      end
      step();
    end
    issue_valid = 1'b0;
    check("stream_rx_count", 32'(rx),              16);
    check("stream_stalls",   32'(stalls),          0);
    check("stream_first",    32'(first_c),         32'(L + 1));
    check("stream_span",     32'(last_c - first_c), 15);
    step();
    check("stream_drained",  32'(inflight),        0);

    // Backpressure: consumer stalled, issuer tries every cycle.
    res_ready = 1'b0; acc = 0;
    issue_op = OP_MUL; issue_fmt = FP16;
    for (int c = 0; c < 8; c++) begin
      issue_valid = 1'b1;
      issue_tag   = TW'(acc);
      cur_dp      = 32'hB000_0000 + 32'(acc);
      if (issue_ready) acc++;
      step();
    end
    issue_valid = 1'b0;
    repeat (L + 1) step();
    check("bp_accepted", 32'(acc),         D);
    check("bp_ready",    32'(issue_ready), 0);
    check("bp_inflight", 32'(inflight),    D);
    check("bp_head_tag", 32'(res_tag),     0);
    repeat (3) step();
    check("bp_hold_valid", 32'(res_valid), 1);
    check("bp_hold_tag",   32'(res_tag),   0);
    check("bp_hold_data",  res_data,       32'hB000_0000);
    res_ready = 1'b1; rx = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) begin
        check("bp_order_tag",  32'(res_tag), 32'(rx));
        check("bp_order_data", res_data,     32'hB000_0000 + 32'(rx));
        rx++;
      end
      step();
    end
    check("bp_rx_count",     32'(rx),          D);
    check("bp_inflight_end", 32'(inflight),    0);
    check("bp_ready_end",    32'(issue_ready), 1);

    // Reset with 2 ops in flight and 1 result sitting in the FIFO.
    res_ready = 1'b0;
    issue_op = OP_ADD; issue_fmt = FP32;
    for (int k = 1; k <= 3; k++) begin
      issue_valid = 1'b1;
      issue_tag   = TW'(k);
      cur_dp      = 32'h5000_0000 + 32'(k);
      step();
    end
    issue_valid = 1'b0;
    check("pre_rst_valid",    32'(res_valid), 1);
    check("pre_rst_inflight", 32'(inflight),  3);
    rst = 1'b1;
    #1;
    check("in_rst_ready", 32'(issue_ready), 0);
    step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (res_valid || inflight != 0) bad++;
    end
    check("post_rst_quiet",    32'(bad),         0);
    check("post_rst_inflight", 32'(inflight),    0);
    check("post_rst_ready2",   32'(issue_ready), 1);
    res_ready = 1'b1;
    issue_and_wait(4'hA, OP_MUL, FP32, 32'h3F80_0000, lat);
    check("post_rst_latency", 32'(lat),     32'(L + 1));
    check("post_rst_tag",     32'(res_tag), 32'hA);
    check("post_rst_data",    res_data,     32'h3F80_0000);
    step();
    check("post_rst_single",  32'(res_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
